wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 148 ++++++++++++++
 tb/tb_wb_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback stage for a scalar/vector execution pipeline.
//
// Accepts one EXEC result bundle per valid/ready handshake and turns it into
// register-file writes:
//   kind 00 : one scalar write of resALUe           (1 cycle)
//   kind 01 : eight 24-bit lane writes of resALUve  (8 cycles, lanes 0..7)
//   kind 10 : eight 24-bit lane writes of resSum    (8 cycles, lanes 0..7)
//   kind 11 : NOP, no write, done pulse only
// All outputs are registered; the first write appears the cycle after accept.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : bundle handshake (in_ready low only for lanes 0..6)
//   exc[4:3]            : result kind; exc[2:0] is not used here
//   rd                  : destination register index
//   resALUe/resALUve/resSum : candidate results
//   we_s, wa_s, wd_s    : scalar register file write port
//   we_v, wa_v, lane, wd_v : vector register file lane write port
//   done                : one-cycle pulse when a bundle completes writeback
// -----------------------------------------------------------------------------
module wb_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [4:0]   exc,
   input  logic [4:0]   rd,
   input  logic [20:0]  resALUe,
   input  logic [191:0] resALUve,
   input  logic [191:0] resSum,
   output logic         we_s,
   output logic [4:0]   wa_s,
   output logic [20:0]  wd_s,
   output logic         we_v,
   output logic [4:0]   wa_v,
   output logic [2:0]   lane,
   output logic [23:0]  wd_v,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAL = 2'd1,
      VEC  = 2'd2
   } state_t;

   state_t         state;
   logic [2:0]     lane_cnt;
   logic [4:0]     cap_rd;
   logic [191:0]   cap_vec;

   logic           accept;
   logic [1:0]     kind;
   logic [191:0]   sel_vec;
   logic [2:0]     lane_nxt;
   logic           unused_exc_bits;

   // Extract the 24-bit slice for lane idx (base = 24*idx = 16*idx + 8*idx).
   function automatic logic [23:0] lane_slice(input logic [191:0] v, input logic [2:0] idx);
      logic [7:0] base;
      base = {2'b00, idx, 3'b000} + {1'b0, idx, 4'b0000};
      return v[base +: 24];
   endfunction

   assign accept          = in_valid & in_ready;
   assign kind            = exc[4:3];
   assign sel_vec         = (kind == 2'b01) ? resALUve : resSum;
   assign lane_nxt        = lane_cnt + 3'd1;
   assign unused_exc_bits = ^exc[2:0];

   // Writeback FSM: captures bundles, sequences lanes and registers every output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lane_cnt <= 3'd0;
         cap_rd   <= 5'd0;
         cap_vec  <= 192'd0;
         in_ready <= 1'b0;
         we_s     <= 1'b0;
         wa_s     <= 5'd0;
         wd_s     <= 21'd0;
         we_v     <= 1'b0;
         wa_v     <= 5'd0;
         lane     <= 3'd0;
         wd_v     <= 24'd0;
         done     <= 1'b0;
      end else begin
         // Write ports are zero unless the branch below drives a write.
         we_s <= 1'b0;
         wa_s <= 5'd0;
         wd_s <= 21'd0;
         we_v <= 1'b0;
         wa_v <= 5'd0;
         lane <= 3'd0;
         wd_v <= 24'd0;
         done <= 1'b0;

         if ((state == VEC) && (lane_cnt != 3'd7)) begin
            // Mid-vector: advance one lane from the captured copy only.
            lane_cnt <= lane_nxt;
            we_v     <= 1'b1;
            wa_v     <= cap_rd;
            lane     <= lane_nxt;
            wd_v     <= lane_slice(cap_vec, lane_nxt);
            // Reopen the handshake as lane 7 goes out so the next bundle
            // can be taken with no bubble.
            in_ready <= (lane_cnt == 3'd6);
            done     <= (lane_cnt == 3'd6);
         end else begin
            // IDLE, SCAL or VEC lane 7: free to take a new bundle.
            in_ready <= 1'b1;
            lane_cnt <= 3'd0;
            if (accept) begin
               cap_rd <= rd;
               case (kind)
                  2'b00: begin
                     state <= SCAL;
                     we_s  <= 1'b1;
                     wa_s  <= rd;
                     wd_s  <= resALUe;
                     done  <= 1'b1;
                  end
                  2'b01, 2'b10: begin
                     state    <= VEC;
                     cap_vec  <= sel_vec;
                     we_v     <= 1'b1;
                     wa_v     <= rd;
                     lane     <= 3'd0;
                     wd_v     <= sel_vec[23:0];
                     in_ready <= 1'b0;
                  end
                  2'b11: begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
                  default: begin
                     state <= IDLE;
                  end
               endcase
            end else begin
               state <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// The reference model is a queue of pending writeback records: each accepted
// bundle appends the per-cycle writes it should produce, one record is
// retired per clock, and the design is ready whenever at most one record
// (the one currently showing) remains.
// -----------------------------------------------------------------------------
module tb_wb_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   exc;
   logic [4:0]   rd;
   logic [20:0]  resALUe;
   logic [191:0] resALUve;
   logic [191:0] resSum;
   logic         we_s;
   logic [4:0]   wa_s;
   logic [20:0]  wd_s;
   logic         we_v;
   logic [4:0]   wa_v;
   logic [2:0]   lane;
   logic [23:0]  wd_v;
   logic         done;

   int errors = 0;
   int checks = 0;

   wb_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .exc(exc), .rd(rd), .resALUe(resALUe), .resALUve(resALUve), .resSum(resSum),
      .we_s(we_s), .wa_s(wa_s), .wd_s(wd_s),
      .we_v(we_v), .wa_v(wa_v), .lane(lane), .wd_v(wd_v), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we_s;
      logic [4:0]  wa_s;
      logic [20:0] wd_s;
      logic        we_v;
      logic [4:0]  wa_v;
      logic [2:0]  lane;
      logic [23:0] wd_v;
      logic        done;
   } rec_t;

   rec_t q[$];
   bit   ready_flag = 1'b0;

   function automatic rec_t empty_rec();
      rec_t r;
      r.we_s = 1'b0; r.wa_s = 5'd0; r.wd_s = 21'd0;
      r.we_v = 1'b0; r.wa_v = 5'd0; r.lane = 3'd0; r.wd_v = 24'd0;
      r.done = 1'b0;
      return r;
   endfunction

   function automatic bit exp_ready();
      return ready_flag && (q.size() <= 1);
   endfunction

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs as they stand now.
   task automatic model_edge();
      bit           acc;
      rec_t         r;
      logic [191:0] v;
      acc = (in_valid === 1'b1) && exp_ready();
      if (rst) begin
         q.delete();
         ready_flag = 1'b0;
      end else begin
         if (q.size() > 0) void'(q.pop_front());
         ready_flag = 1'b1;
         if (acc) begin
            case (exc[4:3])
               2'b00: begin
                  r = empty_rec();
                  r.we_s = 1'b1; r.wa_s = rd; r.wd_s = resALUe; r.done = 1'b1;
                  q.push_back(r);
               end
               2'b11: begin
                  r = empty_rec();
                  r.done = 1'b1;
                  q.push_back(r);
               end
               default: begin
                  v = (exc[4:3] == 2'b01) ? resALUve : resSum;
                  for (int k = 0; k < 8; k++) begin
                     r = empty_rec();
                     r.we_v = 1'b1; r.wa_v = rd; r.lane = 3'(k);
                     r.wd_v = v[24*k +: 24]; r.done = (k == 7);
                     q.push_back(r);
                  end
               end
            endcase
         end
      end
   endtask

   task automatic check_all(input string ph);
      rec_t e;
      e = (q.size() > 0) ? q[0] : empty_rec();
      chk({ph, ".in_ready"}, in_ready, exp_ready());
      chk({ph, ".we_s"}, we_s, e.we_s);
      chk({ph, ".wa_s"}, wa_s, e.wa_s);
      chk({ph, ".wd_s"}, wd_s, e.wd_s);
      chk({ph, ".we_v"}, we_v, e.we_v);
      chk({ph, ".wa_v"}, wa_v, e.wa_v);
      chk({ph, ".lane"}, lane, e.lane);
      chk({ph, ".wd_v"}, wd_v, e.wd_v);
      chk({ph, ".done"}, done, e.done);
      chk({ph, ".excl"}, we_s & we_v, 1'b0);
   endtask

   task automatic step(input string ph);
      model_edge();
      @(posedge clk);
      #1;
      check_all(ph);
   endtask

   function automatic logic [191:0] rand_vec();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [191:0] v;
      rst = 1'b1; in_valid = 1'b0; exc = 5'd0; rd = 5'd0;
      resALUe = 21'd0; resALUve = 192'd0; resSum = 192'd0;

      // Reset and release.
      step("rst0");
      step("rst1");
      chk("rst.in_ready_low", in_ready, 1'b0);
      rst = 1'b0;
      step("release");
      chk("release.in_ready_high", in_ready, 1'b1);

      // Scalar bundle.
      in_valid = 1'b1; exc = 5'b00101; rd = 5'd3; resALUe = 21'h1ABCD;
      step("scal");
      chk("scal.wd_const", wd_s, 21'h1ABCD);
      chk("scal.wa_const", wa_s, 5'd3);
      in_valid = 1'b0;
      step("scal_idle");

      // Vector bundle, lane k = 0x10 + k.
      for (int k = 0; k < 8; k++) v[24*k +: 24] = 24'h000010 + 24'(k);
      resALUve = v; in_valid = 1'b1; exc = 5'b01010; rd = 5'd7;
      step("vec_l0");
      in_valid = 1'b0;
      for (int k = 1; k < 8; k++) step("vec_lk");
      chk("vec.last_wd_const", wd_v, 24'h000017);
      chk("vec.last_done", done, 1'b1);
      step("vec_idle");

      // resSum bundle with rd=0, scalar bundle held valid behind it.
      resSum = rand_vec(); exc = 5'b10000; rd = 5'd0; in_valid = 1'b1;
      step("sum_l0");
      exc = 5'b00011; rd = 5'd9; resALUe = 21'h0F0F0;
      for (int k = 1; k < 8; k++) step("sum_lk");
      step("sum_scal");
      chk("b2b.we_s", we_s, 1'b1);
      chk("b2b.wa_s", wa_s, 5'd9);
      in_valid = 1'b0;
      step("b2b_idle");

      // NOP bundle.
      exc = 5'b11111; rd = 5'd12; in_valid = 1'b1;
      step("nop");
      chk("nop.done", done, 1'b1);
      in_valid = 1'b0;
      step("nop_idle");

      // Reset at lane 3, with a bundle offered on the reset edge.
      resALUve = rand_vec(); exc = 5'b01000; rd = 5'd21; in_valid = 1'b1;
      step("rv_l0");
      exc = 5'b00000; resALUe = 21'h12345;
      for (int k = 1; k < 4; k++) step("rv_lk");
      rst = 1'b1;
      step("rv_rst");
      chk("rv.we_v_off", we_v, 1'b0);
      rst = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < 6; k++) step("rv_after");

      // Inputs churn during VEC while valid stays high.
      resALUve = rand_vec(); exc = 5'b01000; rd = 5'd30; in_valid = 1'b1;
      step("ch_l0");
      for (int k = 1; k < 8; k++) begin
         exc = 5'($urandom); rd = 5'($urandom); resALUe = 21'($urandom);
         resALUve = rand_vec(); resSum = rand_vec();
         step("ch_lk");
      end
      in_valid = 1'b0;
      for (int k = 0; k < 9; k++) step("ch_tail");

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 39) == 0);
         in_valid = ($urandom_range(0, 2) != 0);
         exc      = 5'($urandom);
         rd       = 5'($urandom);
         resALUe  = 21'($urandom);
         resALUve = rand_vec();
         resSum   = rand_vec();
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
